// File: rtl/arm_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package arm_wb_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 16;

  // One buffered register-file write.
  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] result;
  } wb_req_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // One-hot register mask for idx, or all-zero when en is low.
  function automatic logic [NUM_REGS-1:0] reg_decode(input logic [ADDR_W-1:0] idx,
                                                     input logic              en);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (en) m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_slot.sv
// Single-entry holding slot with valid/ready handshake for one write-back producer.
// The bypass input lets the top take an accepted write straight to its output
// register, in which case the slot accepts the handshake but stays empty.
module wb_slot
  import arm_wb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    valid,
  input  wb_req_t req_in,
  input  logic    grant,
  input  logic    bypass,
  output logic    ready,
  output logic    full,
  output logic    fill,
  output wb_req_t held
);

  slot_state_e state_q;
  wb_req_t     held_q;
  logic        accept;

  // Ready also opens on the cycle the held entry is granted, allowing back-to-back refill.
  always_comb begin
    ready  = !rst && ((state_q == SLOT_EMPTY) || grant);
    accept = valid && ready;
    fill   = accept && !bypass;
  end

  // Slot FSM and payload capture; payload only changes on an accepted, non-bypassed write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      held_q  <= '0;
    end else begin
      case (state_q)
        SLOT_EMPTY: if (fill) state_q <= SLOT_FULL;
        SLOT_FULL:  if (grant && !fill) state_q <= SLOT_EMPTY;
      endcase
      if (fill) held_q <= req_in;
    end
  end

  assign full = (state_q == SLOT_FULL);
  assign held = held_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: EXE and MEM producers each own one holding slot, and an
// age-ordered scheduler retires one slot per cycle into the registered write port.
// Optional build macro WB_ARB_BYPASS_EN: a lone write arriving while both slots are
// empty goes straight to the output register on its accepting edge.
// DATA_W/ADDR_W/NUM_REGS must match arm_wb_pkg, and NUM_REGS must equal 2**ADDR_W.
module wb_port_arbiter #(
  parameter int unsigned DATA_W   = arm_wb_pkg::DATA_W,
  parameter int unsigned ADDR_W   = arm_wb_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = arm_wb_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [ADDR_W-1:0]   ex_dest,
  input  logic [DATA_W-1:0]   ex_result,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [ADDR_W-1:0]   mem_dest,
  input  logic [DATA_W-1:0]   mem_result,
  output logic                wb_en,
  output logic [ADDR_W-1:0]   wb_dest,
  output logic [DATA_W-1:0]   wb_result,
  output logic [NUM_REGS-1:0] pending_mask
);

  import arm_wb_pkg::wb_req_t;
  import arm_wb_pkg::reg_decode;

  wb_req_t ex_req_in, mem_req_in, ex_held, mem_held;
  logic    ex_full, mem_full, ex_fill, mem_fill;
  logic    ex_grant, mem_grant, ex_byp, mem_byp;
  logic    ex_stays, mem_stays;
  logic    mem_older_q;

  logic              wb_en_d, wb_en_q;
  logic [ADDR_W-1:0] wb_dest_d, wb_dest_q;
  logic [DATA_W-1:0] wb_result_d, wb_result_q;

  assign ex_req_in  = '{dest: ex_dest,  result: ex_result};
  assign mem_req_in = '{dest: mem_dest, result: mem_result};

  wb_slot u_ex_slot (
    .clk    (clk),
    .rst    (rst),
    .valid  (ex_valid),
    .req_in (ex_req_in),
    .grant  (ex_grant),
    .bypass (ex_byp),
    .ready  (ex_ready),
    .full   (ex_full),
    .fill   (ex_fill),
    .held   (ex_held)
  );

  wb_slot u_mem_slot (
    .clk    (clk),
    .rst    (rst),
    .valid  (mem_valid),
    .req_in (mem_req_in),
    .grant  (mem_grant),
    .bypass (mem_byp),
    .ready  (mem_ready),
    .full   (mem_full),
    .fill   (mem_fill),
    .held   (mem_held)
  );

  // Grant the only full slot, or the older one when both are full.
  always_comb begin
    mem_grant = mem_full && (!ex_full || mem_older_q);
    ex_grant  = ex_full && (!mem_full || !mem_older_q);
    ex_stays  = ex_full && !ex_grant;
    mem_stays = mem_full && !mem_grant;
  end

  // Bypass selection: only with both slots empty; MEM wins when both producers offer.
  always_comb begin
`ifdef WB_ARB_BYPASS_EN
    mem_byp = !rst && !ex_full && !mem_full && mem_valid;
    ex_byp  = !rst && !ex_full && !mem_full && ex_valid && !mem_valid;
`else
    mem_byp = 1'b0;
    ex_byp  = 1'b0;
`endif
  end

  // Age flag: set when MEM holds the older entry. A same-edge double fill counts MEM as older.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_older_q <= 1'b0;
    end else if (mem_fill && ex_stays) begin
      mem_older_q <= 1'b0;
    end else if (ex_fill && (mem_stays || mem_fill)) begin
      mem_older_q <= 1'b1;
    end
  end

  // Next write-port contents: bypassed write, granted slot, or idle with dest/result held.
  always_comb begin
    wb_en_d     = 1'b0;
    wb_dest_d   = wb_dest_q;
    wb_result_d = wb_result_q;
    if (mem_byp) begin
      wb_en_d     = 1'b1;
      wb_dest_d   = mem_dest;
      wb_result_d = mem_result;
    end else if (ex_byp) begin
      wb_en_d     = 1'b1;
      wb_dest_d   = ex_dest;
      wb_result_d = ex_result;
    end else if (mem_grant) begin
      wb_en_d     = 1'b1;
      wb_dest_d   = mem_held.dest;
      wb_result_d = mem_held.result;
    end else if (ex_grant) begin
      wb_en_d     = 1'b1;
      wb_dest_d   = ex_held.dest;
      wb_result_d = ex_held.result;
    end
  end

  // Registered write port to the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q     <= 1'b0;
      wb_dest_q   <= '0;
      wb_result_q <= '0;
    end else begin
      wb_en_q     <= wb_en_d;
      wb_dest_q   <= wb_dest_d;
      wb_result_q <= wb_result_d;
    end
  end

  assign wb_en     = wb_en_q;
  assign wb_dest   = wb_dest_q;
  assign wb_result = wb_result_q;

  // Every register with a write still buffered or currently on the write port.
  always_comb begin
    pending_mask = reg_decode(ex_held.dest, ex_full)
                 | reg_decode(mem_held.dest, mem_full)
                 | reg_decode(wb_dest_q, wb_en_q);
  end

endmodule
